pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (F, D, E, M, W).
- Drives the enable and clear inputs of the PC register and of the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use and branch-operand hazards, multi-cycle MDU (mult/div) waits, data-memory wait states and exception flushes.
- Sits beside the datapath and contains no data storage beyond its FSM and the optional counter.

Parameters:
- REGW, 5, register-index width.
- CNTW, 32, width of the optional stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_d, rt_d  in  REGW  source register indices in D.
- branch_d  in  1  D holds a branch/jr that compares operands in D.
- writereg_e, writereg_m  in  REGW  destination register indices in E and M.
- regwrite_e  in  1  E instruction writes the register file.
- memtoreg_e, memtoreg_m  in  1  E/M instruction is a load.
- mdu_op_e  in  1  E holds a mult/div.
- mdu_done  in  1  one-cycle MDU completion pulse.
- dmem_req_m  in  1  M issues a data-memory access.
- dmem_ack  in  1  data memory completes the access this cycle.
- imem_stall  in  1  instruction fetch is not ready.
- exc_m  in  1  exception detected in M.
- en_pc, en_d, en_e, en_m, en_w  out  1  register enables.
- clr_d, clr_e, clr_m, clr_w  out  1  synchronous bubble insertion.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_cancel  out  1  abort the in-flight MDU operation.
- exc_redirect  out  1  selects the exception vector 0xbfc00380 for pcnext.
- stall_cycles  out  CNTW  performance counter (see Optional Feature).

Behaviour:
- Outputs are combinational from state and inputs. The FSM state register is reset asynchronously to RUN.
- While reset is low: all en_*, clr_*, mdu_start, mdu_cancel and exc_redirect are 0.
- Hazard terms (a register index of 0 never matches):
  - lwstall = memtoreg_e & regwrite_e & (writereg_e==rs_d | writereg_e==rt_d).
  - brstall = branch_d & ((regwrite_e & writereg_e matches rs_d/rt_d) | (memtoreg_m & writereg_m matches rs_d/rt_d)).
- Default output set: all en=1, all clr=0.
- FSM states and priority within each state (highest first):
  - RUN:
    - exc_m: clr_d=clr_e=clr_m=1, exc_redirect=1; next state FLUSH.
    - dmem_req_m & !dmem_ack: en_pc..en_m=0, clr_w=1; next state MEM_WAIT.
    - mdu_op_e: mdu_start=1, en_pc=en_d=en_e=0, clr_m=1; next state MDU_WAIT.
    - lwstall | brstall: en_pc=en_d=0, clr_e=1; stay in RUN.
    - imem_stall: en_pc=0, clr_d=1; stay in RUN.
  - MEM_WAIT:
    - exc_m: treated as in RUN, next state FLUSH.
    - !dmem_ack: hold en_pc..en_m=0, clr_w=1.
    - dmem_ack: default output set; next state RUN.
  - MDU_WAIT:
    - exc_m: mdu_cancel=1 plus the RUN exception outputs; next state FLUSH.
    - !mdu_done: en_pc=en_d=en_e=0, clr_m=1.
    - mdu_done: default output set; next state RUN. mdu_start is never reasserted for the same E instruction.
  - FLUSH (exactly 1 cycle): clr_d=1 kills the wrong-path fetch; next state RUN. Hazard stalls are ignored in this cycle.
- Simultaneous mdu_done and exc_m: the exception wins; mdu_cancel=1.
- dmem_ack arriving in RUN together with dmem_req_m: no wait state is entered.
- Reset asserted mid-wait: returns to RUN immediately; no pulse is emitted on reset release.
- State encoding is 2 bits: RUN=0, MEM_WAIT=1, MDU_WAIT=2, FLUSH=3.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: stall_cycles increments by 1 on each clock edge where reset is high and en_pc=0. It wraps at 2^CNTW and is cleared to 0 by reset.
- Undefined: stall_cycles is tied to 0 and no counter flops are generated.

Test Plan:
- Reset low for 3 cycles, then high with all inputs 0 -> all outputs 0 during reset; after release, en_*=1, clr_*=0, state RUN.
- memtoreg_e=1, regwrite_e=1, writereg_e=5, rs_d=5 for one cycle -> en_pc=en_d=0, clr_e=1 for that cycle; writereg_e=0 with the same setup -> no stall.
- mdu_op_e=1, then mdu_done after 4 cycles -> mdu_start high for exactly 1 cycle; en_e=0 and clr_m=1 for 4 cycles; all en=1 on the done cycle.
- dmem_req_m=1 with dmem_ack delayed 3 cycles -> en_m=0, clr_w=1 for 3 cycles; release on the ack cycle.
- exc_m=1 during MDU_WAIT -> mdu_cancel=1, exc_redirect=1, clr_d/e/m=1; next cycle FLUSH with clr_d=1; then RUN.
- With PIPE_STALL_CNT_EN: 7 stalled cycles -> stall_cycles=7; without the macro -> stall_cycles stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath (master) and the stall/flush
// sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 32
);
    logic [REGW-1:0] rs_d;
    logic [REGW-1:0] rt_d;
    logic            branch_d;
    logic [REGW-1:0] writereg_e;
    logic [REGW-1:0] writereg_m;
    logic            regwrite_e;
    logic            memtoreg_e;
    logic            memtoreg_m;
    logic            mdu_op_e;
    logic            mdu_done;
    logic            dmem_req_m;
    logic            dmem_ack;
    logic            imem_stall;
    logic            exc_m;

    logic            en_pc;
    logic            en_d;
    logic            en_e;
    logic            en_m;
    logic            en_w;
    logic            clr_d;
    logic            clr_e;
    logic            clr_m;
    logic            clr_w;
    logic            mdu_start;
    logic            mdu_cancel;
    logic            exc_redirect;
    logic [CNTW-1:0] stall_cycles;

    modport master (
        output rs_d, rt_d, branch_d, writereg_e, writereg_m, regwrite_e, memtoreg_e,
               memtoreg_m, mdu_op_e, mdu_done, dmem_req_m, dmem_ack, imem_stall, exc_m,
        input  en_pc, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w, mdu_start,
               mdu_cancel, exc_redirect, stall_cycles
    );

    modport slave (
        input  rs_d, rt_d, branch_d, writereg_e, writereg_m, regwrite_e, memtoreg_e,
               memtoreg_m, mdu_op_e, mdu_done, dmem_req_m, dmem_ack, imem_stall, exc_m,
        output en_pc, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w, mdu_start,
               mdu_cancel, exc_redirect, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Define PIPE_STALL_CNT_EN to
// build the stall_cycles performance counter; otherwise it is tied to zero.
module pipe_hazard_ctrl #(
    parameter int unsigned REGW = 5,
    parameter int unsigned CNTW = 32
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StMduWait = 2'd2,
        StFlush   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic lwstall, brstall;

    logic en_pc, en_d, en_e, en_m, en_w;
    logic clr_d, clr_e, clr_m, clr_w;
    logic mdu_start, mdu_cancel, exc_redirect;

    // A zero source index is $zero and never forwards or stalls.
    assign rs_hit_e = (bus.rs_d != {REGW{1'b0}}) && (bus.rs_d == bus.writereg_e);
    assign rt_hit_e = (bus.rt_d != {REGW{1'b0}}) && (bus.rt_d == bus.writereg_e);
    assign rs_hit_m = (bus.rs_d != {REGW{1'b0}}) && (bus.rs_d == bus.writereg_m);
    assign rt_hit_m = (bus.rt_d != {REGW{1'b0}}) && (bus.rt_d == bus.writereg_m);

    assign lwstall = bus.memtoreg_e & bus.regwrite_e & (rs_hit_e | rt_hit_e);
    assign brstall = bus.branch_d & ((bus.regwrite_e & (rs_hit_e | rt_hit_e)) |
                                     (bus.memtoreg_m & (rs_hit_m | rt_hit_m)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        en_pc        = 1'b1;
        en_d         = 1'b1;
        en_e         = 1'b1;
        en_m         = 1'b1;
        en_w         = 1'b1;
        clr_d        = 1'b0;
        clr_e        = 1'b0;
        clr_m        = 1'b0;
        clr_w        = 1'b0;
        mdu_start    = 1'b0;
        mdu_cancel   = 1'b0;
        exc_redirect = 1'b0;

        case (state_q)
            StRun: begin
                if (bus.exc_m) begin
                    clr_d        = 1'b1;
                    clr_e        = 1'b1;
                    clr_m        = 1'b1;
                    exc_redirect = 1'b1;
                    state_d      = StFlush;
                end else if (bus.dmem_req_m && !bus.dmem_ack) begin
                    en_pc   = 1'b0;
                    en_d    = 1'b0;
                    en_e    = 1'b0;
                    en_m    = 1'b0;
                    clr_w   = 1'b1;
                    state_d = StMemWait;
                end else if (bus.mdu_op_e) begin
                    mdu_start = 1'b1;
                    en_pc     = 1'b0;
                    en_d      = 1'b0;
                    en_e      = 1'b0;
                    clr_m     = 1'b1;
                    state_d   = StMduWait;
                end else if (lwstall || brstall) begin
                    en_pc = 1'b0;
                    en_d  = 1'b0;
                    clr_e = 1'b1;
                end else if (bus.imem_stall) begin
                    en_pc = 1'b0;
                    clr_d = 1'b1;
                end
            end
            StMemWait: begin
                if (bus.exc_m) begin
                    clr_d        = 1'b1;
                    clr_e        = 1'b1;
                    clr_m        = 1'b1;
                    exc_redirect = 1'b1;
                    state_d      = StFlush;
                end else if (!bus.dmem_ack) begin
                    en_pc = 1'b0;
                    en_d  = 1'b0;
                    en_e  = 1'b0;
                    en_m  = 1'b0;
                    clr_w = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StMduWait: begin
                // Exception beats a same-cycle mdu_done; the result is discarded.
                if (bus.exc_m) begin
                    mdu_cancel   = 1'b1;
                    clr_d        = 1'b1;
                    clr_e        = 1'b1;
                    clr_m        = 1'b1;
                    exc_redirect = 1'b1;
                    state_d      = StFlush;
                end else if (!bus.mdu_done) begin
                    en_pc = 1'b0;
                    en_d  = 1'b0;
                    en_e  = 1'b0;
                    clr_m = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                clr_d   = 1'b1;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase

        if (!reset) begin
            en_pc        = 1'b0;
            en_d         = 1'b0;
            en_e         = 1'b0;
            en_m         = 1'b0;
            en_w         = 1'b0;
            clr_d        = 1'b0;
            clr_e        = 1'b0;
            clr_m        = 1'b0;
            clr_w        = 1'b0;
            mdu_start    = 1'b0;
            mdu_cancel   = 1'b0;
            exc_redirect = 1'b0;
        end
    end

    assign bus.en_pc        = en_pc;
    assign bus.en_d         = en_d;
    assign bus.en_e         = en_e;
    assign bus.en_m         = en_m;
    assign bus.en_w         = en_w;
    assign bus.clr_d        = clr_d;
    assign bus.clr_e        = clr_e;
    assign bus.clr_m        = clr_m;
    assign bus.clr_w        = clr_w;
    assign bus.mdu_start    = mdu_start;
    assign bus.mdu_cancel   = mdu_cancel;
    assign bus.exc_redirect = exc_redirect;

`ifdef PIPE_STALL_CNT_EN
    logic [CNTW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNTW{1'b0}};
        end else if (!en_pc) begin
            cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign bus.stall_cycles = cnt_q;
`else
    assign bus.stall_cycles = {CNTW{1'b0}};
`endif

endmodule
